sample_capture: RTL and testbench

- Receive end of the 24-bit sample stream produced by the team's test-signal generators (clean or noisy sine).
- Captures a window of 2^DEPTH_LOG2 samples into on-chip RAM once armed.
- Plays the window back over a simple request/valid read port to the filter-evaluation logic or debug readout.
- Used on the Nexys Video board and in benches as the standard stream sink.

---
 rtl/sample_capture_pkg.sv | 15 +
 rtl/sample_capture_if.sv | 28 ++
 rtl/sample_capture_ram.sv | 40 ++++
 rtl/sample_capture.sv | 147 ++++++++++++++
 tb/tb_sample_capture.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_capture_pkg.sv
// Shared constants for the sample_capture stream sink: default widths and FSM state encoding.
// The optional statistics outputs are enabled by defining SAMPLE_CAPTURE_STATS_EN.
package sample_capture_pkg;

    localparam int unsigned DEFAULT_DATA_W     = 24;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_READ = 2'd3
    } cap_state_e;

endpackage

// File: rtl/sample_capture_if.sv
// Stream-in, control and read-back signals of sample_capture; master = producer/reader, slave = capture block.
interface sample_capture_if
    import sample_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              arm;
    logic              busy;
    logic              done;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;

    modport master (
        output in_data, in_valid, arm, rd_req,
        input  busy, done, rd_data, rd_valid, rd_last
    );

    modport slave (
        input  in_data, in_valid, arm, rd_req,
        output busy, done, rd_data, rd_valid, rd_last
    );

endinterface

// File: rtl/sample_capture_ram.sv
// sample_ram: simple dual-port RAM, one write port and one registered read port (block-RAM friendly).
module sample_ram
    import sample_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_DEPTH_LOG2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register clears on reset so read data reads zero until the first read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sample_capture.sv
// Captures a 2^DEPTH_LOG2 window of decimated stream samples once armed, then plays it back in order.
// Define SAMPLE_CAPTURE_STATS_EN to add signed min/max tracking of the captured window.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int unsigned DECIM      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    sample_capture_if.slave          bus
`ifdef SAMPLE_CAPTURE_STATS_EN
    ,
    output logic signed [DATA_W-1:0] stat_min,
    output logic signed [DATA_W-1:0] stat_max
`endif
);

    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

    cap_state_e            r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_dec_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_W-1:0]     w_rd_q;

    assign w_wr_en = (r_state == ST_FILL) && bus.in_valid && (r_dec_cnt == '0);
    // A request in the rd_last cycle is dropped: the window is already exhausted.
    assign w_rd_en = bus.rd_req &&
                     ((r_state == ST_DONE) || ((r_state == ST_READ) && !r_rd_last));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dec_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            r_rd_last  <= w_rd_en && (r_rd_ptr == LAST_ADDR);
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        r_state   <= ST_FILL;
                        r_busy    <= 1'b1;
                        r_wr_ptr  <= '0;
                        r_rd_ptr  <= '0;
                        r_dec_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (bus.in_valid) begin
                        r_dec_cnt <= (r_dec_cnt == CNT_W'(DECIM - 1)) ? '0
                                                                      : r_dec_cnt + CNT_W'(1);
                    end
                    if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                        if (r_wr_ptr == LAST_ADDR) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_rd_en) begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_rd_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.in_data),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_q)
    );

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_data  = w_rd_q;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_last  = r_rd_last;

`ifdef SAMPLE_CAPTURE_STATS_EN
    logic signed [DATA_W-1:0] r_stat_min;
    logic signed [DATA_W-1:0] r_stat_max;
    logic signed [DATA_W-1:0] w_sample;

    assign w_sample = $signed(bus.in_data);

    // The first write of a window seeds both extremes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_min <= '0;
            r_stat_max <= '0;
        end else if (w_wr_en) begin
            if (r_wr_ptr == '0) begin
                r_stat_min <= w_sample;
                r_stat_max <= w_sample;
            end else begin
                if (w_sample < r_stat_min) begin
                    r_stat_min <= w_sample;
                end
                if (w_sample > r_stat_max) begin
                    r_stat_max <= w_sample;
                end
            end
        end
    end

    assign stat_min = r_stat_min;
    assign stat_max = r_stat_max;
`endif

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: DECIM=1 and DECIM=3 instances share stimulus; expected windows come from the sent-sample list.
`timescale 1ns/1ps
module tb_sample_capture;

    localparam int unsigned DW    = 24;
    localparam int unsigned DL    = 4;
    localparam int          DEPTH = 16;
    localparam int          NEED1 = (DEPTH - 1) * 1 + 1;
    localparam int          NEED3 = (DEPTH - 1) * 3 + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm;
    logic          in_valid;
    logic          rd_req;
    logic [DW-1:0] in_data;

    int n_total;
    int n_bad;

    logic [DW-1:0] sent [$];
    logic [DW-1:0] exp1 [DEPTH];
    logic [DW-1:0] exp3 [DEPTH];

    always #5 clk = ~clk;

    sample_capture_if #(.DATA_W(DW)) if1 ();
    sample_capture_if #(.DATA_W(DW)) if3 ();

    assign if1.arm      = arm;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign if1.rd_req   = rd_req;
    assign if3.arm      = arm;
    assign if3.in_valid = in_valid;
    assign if3.in_data  = in_data;
    assign if3.rd_req   = rd_req;

`ifdef SAMPLE_CAPTURE_STATS_EN
    logic signed [DW-1:0] s_min1, s_max1, s_min3, s_max3;
`endif

    sample_capture #(.DATA_W(DW), .DEPTH_LOG2(DL), .DECIM(1)) u_dut1 (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (if1)
`ifdef SAMPLE_CAPTURE_STATS_EN
        ,
        .stat_min (s_min1),
        .stat_max (s_max1)
`endif
    );

    sample_capture #(.DATA_W(DW), .DEPTH_LOG2(DL), .DECIM(3)) u_dut3 (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (if3)
`ifdef SAMPLE_CAPTURE_STATS_EN
        ,
        .stat_min (s_min3),
        .stat_max (s_max3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy1"}, 32'(if1.busy), 32'd0);
        check({tag, "_done1"}, 32'(if1.done), 32'd0);
        check({tag, "_rv1"},   32'(if1.rd_valid), 32'd0);
        check({tag, "_rl1"},   32'(if1.rd_last), 32'd0);
        check({tag, "_busy3"}, 32'(if3.busy), 32'd0);
        check({tag, "_done3"}, 32'(if3.done), 32'd0);
        check({tag, "_rv3"},   32'(if3.rd_valid), 32'd0);
    endtask

    // Window model: keep every D-th valid sample after arm, first DEPTH of them.
    task automatic build_expected();
        for (int i = 0; i < DEPTH; i++) begin
            exp1[i] = sent[i];
            exp3[i] = sent[3 * i];
        end
    endtask

`ifdef SAMPLE_CAPTURE_STATS_EN
    task automatic check_stats();
        logic signed [DW-1:0] mn1, mx1, mn3, mx3, v;
        mn1 = exp1[0]; mx1 = exp1[0]; mn3 = exp3[0]; mx3 = exp3[0];
        for (int i = 1; i < DEPTH; i++) begin
            v = exp1[i];
            if (v < mn1) mn1 = v;
            if (v > mx1) mx1 = v;
            v = exp3[i];
            if (v < mn3) mn3 = v;
            if (v > mx3) mx3 = v;
        end
        check("stat_min1", {8'h0, s_min1}, {8'h0, mn1});
        check("stat_max1", {8'h0, s_max1}, {8'h0, mx1});
        check("stat_min3", {8'h0, s_min3}, {8'h0, mn3});
        check("stat_max3", {8'h0, s_max3}, {8'h0, mx3});
    endtask
`endif

    task automatic do_fill(input bit rnd, input int base, input int gap, input bit inject);
        int cnt;
        int cyc;
        logic [DW-1:0] d;
        sent.delete();
        cnt = 0;
        cyc = 0;
        // arm together with a valid sample that must not be captured
        @(negedge clk);
        arm = 1'b1; in_valid = 1'b1; in_data = 24'h5A5A5A;
        @(negedge clk);
        arm = 1'b0; in_valid = 1'b0;
        check("arm_busy1", 32'(if1.busy), 32'd1);
        check("arm_busy3", 32'(if3.busy), 32'd1);
        check("arm_done1", 32'(if1.done), 32'd0);
        while (cnt < 48 && cyc < 1000) begin
            cyc++;
            d = rnd ? DW'($urandom) : DW'(base + cnt);
            if (inject && cnt == 3) d = 24'h800000;
            if (inject && cnt == 9) d = 24'h7FFFFF;
            in_valid = ($urandom_range(99) >= 32'(gap));
            in_data  = in_valid ? d : DW'($urandom);
            arm      = (cnt == 2 || cnt == 20);
            rd_req   = (cnt < 12) && ($urandom_range(1) == 1);
            @(negedge clk);
            if (in_valid) begin
                sent.push_back(d);
                cnt++;
            end
            check("fill_busy1", 32'(if1.busy), 32'(cnt < NEED1));
            check("fill_done1", 32'(if1.done), 32'(cnt >= NEED1));
            check("fill_busy3", 32'(if3.busy), 32'(cnt < NEED3));
            check("fill_done3", 32'(if3.done), 32'(cnt >= NEED3));
            check("fill_rv1", 32'(if1.rd_valid), 32'd0);
            check("fill_rv3", 32'(if3.rd_valid), 32'd0);
        end
        if (cnt < 48) check("fill_timeout", 32'(cnt), 32'd48);
        arm = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
        build_expected();
    endtask

    task automatic do_read(input int gap);
        int idx;
        int cyc;
`ifdef SAMPLE_CAPTURE_STATS_EN
        check_stats();
`endif
        idx = 0;
        cyc = 0;
        while (idx < DEPTH && cyc < 500) begin
            cyc++;
            rd_req = ($urandom_range(99) >= 32'(gap));
            @(negedge clk);
            check("rd_done1", 32'(if1.done), 32'd1);
            check("rd_done3", 32'(if3.done), 32'd1);
            if (rd_req) begin
                check("rd_valid1", 32'(if1.rd_valid), 32'd1);
                check("rd_valid3", 32'(if3.rd_valid), 32'd1);
                check("rd_data1", 32'(if1.rd_data), 32'(exp1[idx]));
                check("rd_data3", 32'(if3.rd_data), 32'(exp3[idx]));
                check("rd_last1", 32'(if1.rd_last), 32'(idx == DEPTH - 1));
                check("rd_last3", 32'(if3.rd_last), 32'(idx == DEPTH - 1));
                idx++;
            end else begin
                check("rd_idle1", 32'(if1.rd_valid), 32'd0);
                check("rd_idle3", 32'(if3.rd_valid), 32'd0);
            end
        end
        if (idx < DEPTH) check("read_timeout", 32'(idx), 32'(DEPTH));
        // request during the rd_last cycle is ignored and done drops
        rd_req = 1'b1;
        @(negedge clk);
        check_quiet("post_read");
        rd_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        n_total = 0; n_bad = 0;
        arm = 1'b0; in_valid = 1'b0; rd_req = 1'b0; in_data = '0;
        rst_n = 1'b0;
        #100;
        @(negedge clk);
        check_quiet("reset");
        check("reset_rd1", 32'(if1.rd_data), 32'd0);
        check("reset_rd3", 32'(if3.rd_data), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            @(negedge clk);
            check_quiet("idle_rdreq");
        end
        rd_req = 1'b0;

        // ramp 0..47: DECIM=1 gives 0..15, DECIM=3 gives 0,3,..,45
        do_fill(1'b0, 0, 0, 1'b0);
        do_read(0);

        // random data with full-scale extremes and gaps
        do_fill(1'b1, 0, 30, 1'b1);
        do_read(30);

        // reset after 7 captured samples, then a fresh ramp from 100
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = DW'(200 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_fill");
        @(negedge clk);
        rst_n = 1'b1;
        do_fill(1'b0, 100, 20, 1'b0);
        do_read(0);

        for (int r = 0; r < 3; r++) begin
            do_fill(1'b1, 0, 40, 1'b0);
            do_read(50);
        end

        // reset in the middle of a readout
        do_fill(1'b1, 0, 10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1;
            @(negedge clk);
            check("part_data1", 32'(if1.rd_data), 32'(exp1[i]));
        end
        @(posedge clk);
        #1;
        check("mid_rv1", 32'(if1.rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_read");
        check("rst_read_rd1", 32'(if1.rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_rst_read");
        rd_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
